chacha_xor_stream: RTL and testbench

CHACHA_XOR_STREAM -- requirements
Module: chacha_xor_stream

---
 rtl/chacha_pkg.sv | 25 ++
 rtl/chacha_xor_stream_if.sv | 28 ++
 rtl/reg_256.sv | 17 +
 rtl/chacha_xor_stream.sv | 89 ++++++++
 tb/tb_chacha_xor_stream.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha stream definitions: word/block geometry, the XOR-stage state
// enum and a keystream word selector (word 0 lives in the top bits).
package chacha_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 16;
  localparam int BLK_W         = WORD_W * WORDS_PER_BLK;
  localparam int IDX_W         = 4;

  typedef enum logic [0:0] {
    WAIT_KS = 1'b0,
    RUN     = 1'b1
  } chacha_state_e;

  function automatic logic [WORD_W-1:0] ks_word(input logic [BLK_W-1:0] blk,
                                                input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      if (idx == IDX_W'(i)) w = blk[BLK_W-1-WORD_W*i -: WORD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/chacha_xor_stream_if.sv
// Keystream, input-word and output-word channels of the XOR stage.
// Handshakes: a word moves on a clock edge where valid and ready are both 1;
// valid never waits on ready, and a raised valid holds its data until it moves.
interface chacha_xor_stream_if;
  import chacha_pkg::*;

  logic                ks_req;
  logic                ks_valid;
  logic [BLK_W-1:0]    ks_block;
  logic [WORD_W-1:0]   din;
  logic                din_valid;
  logic                din_ready;
  logic [WORD_W-1:0]   dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [31:0]         blk_count;

  modport master (
    output ks_valid, ks_block, din, din_valid, dout_ready,
    input  ks_req, din_ready, dout, dout_valid, blk_count
  );

  modport slave (
    input  ks_valid, ks_block, din, din_valid, dout_ready,
    output ks_req, din_ready, dout, dout_valid, blk_count
  );

endinterface

// File: rtl/reg_256.sv
// Generic load-enabled register with synchronous active-high clear.
module reg_256 #(
  parameter int WIDTH = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/chacha_xor_stream.sv
// XORs a 32-bit word stream with 512-bit keystream blocks, one keystream word
// per accepted input word, requesting a fresh block after every 16 words.
import chacha_pkg::*;

module chacha_xor_stream (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Restart,
  chacha_xor_stream_if.slave  io,
  output chacha_state_e       state_dbg
);

  chacha_state_e     state;
  logic [IDX_W-1:0]  idx;
  logic [BLK_W-1:0]  ks_buf;
  logic [WORD_W-1:0] dout_q;
  logic              dout_valid_q;
  logic [31:0]       blk_count_q;
  logic              capture;
  logic              din_ready;
  logic              din_fire;
  logic              dout_fire;
  logic              last_word;

  // Capture only from WAIT_KS so a block in use is never overwritten.
  assign capture   = (state == WAIT_KS) && io.ks_valid && !Restart;
  assign din_ready = (state == RUN) && (!dout_valid_q || io.dout_ready) && !Restart && !Reset;
  assign din_fire  = io.din_valid && din_ready;
  assign dout_fire = dout_valid_q && io.dout_ready;
  assign last_word = (idx == IDX_W'(WORDS_PER_BLK - 1));

  reg_256 #(.WIDTH(BLK_W)) u_ks_buf (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (capture),
    .d     (io.ks_block),
    .q     (ks_buf)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= WAIT_KS;
      idx          <= '0;
      blk_count_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else if (Restart) begin
      state        <= WAIT_KS;
      idx          <= '0;
      blk_count_q  <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state)
        WAIT_KS: begin
          if (io.ks_valid) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          if (din_fire) begin
            idx <= idx + 4'd1;
            // Leaving RUN here forces at least one WAIT_KS cycle of din_ready=0.
            if (last_word) begin
              blk_count_q <= blk_count_q + 32'd1;
              state       <= WAIT_KS;
            end
          end
        end
        default: state <= WAIT_KS;
      endcase

      if (din_fire) begin
        dout_q       <= io.din ^ ks_word(ks_buf, idx);
        dout_valid_q <= 1'b1;
      end else if (dout_fire) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign io.ks_req     = (state == WAIT_KS);
  assign io.din_ready  = din_ready;
  assign io.dout       = dout_q;
  assign io.dout_valid = dout_valid_q;
  assign io.blk_count  = blk_count_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Bench for chacha_xor_stream: a keystream-position model predicts each output
// word, and a scoreboard matches every accepted output in order.
import chacha_pkg::*;

module tb_chacha_xor_stream;

  logic          Clk;
  logic          Reset;
  logic          Restart;
  chacha_state_e state_dbg;

  chacha_xor_stream_if bus ();

  chacha_xor_stream dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Restart   (Restart),
    .io        (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current block as 16 words, position in it, blocks used.
  logic [31:0] ks_words [16];
  int          pos       = 0;
  int          model_blk = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_v;
  logic        rand_rdy_en = 1'b0;

  task automatic reset_dut();
    Reset          = 1'b1;
    Restart        = 1'b0;
    bus.ks_valid   = 1'b0;
    bus.ks_block   = '0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    pos       = 0;
    model_blk = 0;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic load_block(input logic [511:0] blk);
    int t = 0;
    while (bus.ks_req !== 1'b1 && t < 50) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL ks_req_timeout ks_req=%b required 1", bus.ks_req);
    end
    bus.ks_block = blk;
    bus.ks_valid = 1'b1;
    @(posedge Clk); #1;
    bus.ks_valid = 1'b0;
    for (int i = 0; i < 16; i++) ks_words[i] = blk[511-32*i -: 32];
    pos = 0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int t = 0;
    bus.din       = d;
    bus.din_valid = 1'b1;
    @(negedge Clk);
    while (bus.din_ready !== 1'b1 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL din_ready_timeout din_ready=%b required 1", bus.din_ready);
      bus.din_valid = 1'b0;
      return;
    end
    exp_q.push_back(d ^ ks_words[pos]);
    pos++;
    if (pos == 16) begin
      pos = 0;
      model_blk++;
    end
    @(posedge Clk); #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.dout_ready = 1'b1;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
    end
  endtask

  // Randomised downstream readiness, updated between task edges.
  always @(posedge Clk) begin
    #2;
    if (rand_rdy_en) bus.dout_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard ----------------
  always @(negedge Clk) begin
    if (!Reset && !Restart && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      got_q.push_back(bus.dout);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected got %h required none", bus.dout);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.dout !== exp_v) begin
          errors++;
          $display("FAIL dout_word got %h required %h", bus.dout, exp_v);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    checks++; if (bus.ks_req !== 1'b1) begin errors++; $display("FAIL reset_ks_req got %b required 1", bus.ks_req); end
    checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %b required 0", bus.din_ready); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b required 0", bus.dout_valid); end
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h required 0", bus.dout); end
    checks++; if (bus.blk_count !== 32'h0) begin errors++; $display("FAIL reset_blk_count got %0d required 0", bus.blk_count); end
    checks++; if (state_dbg !== WAIT_KS) begin errors++; $display("FAIL reset_state got %0d required WAIT_KS", state_dbg); end
  endtask

  task automatic test_counting_block();
    logic [511:0] blk;
    reset_dut();
    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = 32'h01010101 * i;
    load_block(blk);
    for (int i = 0; i < 16; i++) send_word(32'h0);
    drain();
    checks++;
    if (got_q.size() != 16 || got_q[0] !== 32'h0 || got_q[15] !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL count_words got n=%0d last=%h required n=16 last=0f0f0f0f", got_q.size(),
               (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'h0);
    end
    checks++; if (bus.blk_count !== 32'd1) begin errors++; $display("FAIL count_blk got %0d required 1", bus.blk_count); end
  endtask

  task automatic test_deadbeef();
    logic [511:0] blk;
    reset_dut();
    blk = rand_blk();
    blk[511:480] = 32'hDEADBEEF;
    load_block(blk);
    send_word(32'hFFFFFFFF);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 32'h21524110) begin
      errors++;
      $display("FAIL deadbeef_latency got v=%b d=%h required v=1 d=21524110", bus.dout_valid, bus.dout);
    end
    for (int i = 1; i < 16; i++) send_word($urandom());
    drain();
    checks++; if (bus.blk_count !== 32'(model_blk)) begin errors++; $display("FAIL deadbeef_blk got %0d required %0d", bus.blk_count, model_blk); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d [16];
    logic [31:0] hold_v;
    reset_dut();
    load_block(rand_blk());
    for (int i = 0; i < 16; i++) d[i] = $urandom();
    send_word(d[0]);
    bus.dout_ready = 1'b0;
    hold_v = d[0] ^ ks_words[0];
    bus.din       = d[1];
    bus.din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      checks++;
      if (bus.dout !== hold_v || bus.dout_valid !== 1'b1 || bus.din_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got d=%h v=%b rdy=%b required d=%h v=1 rdy=0",
                 c, bus.dout, bus.dout_valid, bus.din_ready, hold_v);
      end
    end
    @(posedge Clk); #1;
    bus.dout_ready = 1'b1;
    for (int i = 1; i < 16; i++) send_word(d[i]);
    drain();
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL hold_word_count got %0d required 16", got_q.size()); end
    checks++; if (bus.blk_count !== 32'd1) begin errors++; $display("FAIL hold_blk got %0d required 1", bus.blk_count); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    load_block({16{32'h55555555}});
    for (int i = 0; i < 16; i++) send_word($urandom());
    checks++; if (bus.blk_count !== 32'd1) begin errors++; $display("FAIL b2b_blk1 got %0d required 1", bus.blk_count); end
    @(negedge Clk);
    checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap din_ready got %b required 0", bus.din_ready); end
    load_block({16{32'hAAAAAAAA}});
    for (int i = 0; i < 16; i++) send_word($urandom());
    checks++; if (bus.blk_count !== 32'd2) begin errors++; $display("FAIL b2b_blk2 got %0d required 2", bus.blk_count); end
    drain();
  endtask

  task automatic test_restart();
    reset_dut();
    load_block(rand_blk());
    for (int i = 0; i < 7; i++) send_word($urandom());
    bus.dout_ready = 1'b0;
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL restart_pre_valid got %b required 1", bus.dout_valid); end
    Restart = 1'b1;
    @(negedge Clk);
    checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL restart_din_ready got %b required 0", bus.din_ready); end
    @(posedge Clk); #1;
    Restart = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.ks_req !== 1'b1 || bus.blk_count !== 32'h0) begin
      errors++;
      $display("FAIL restart_clear got v=%b req=%b blk=%0d required v=0 req=1 blk=0",
               bus.dout_valid, bus.ks_req, bus.blk_count);
    end
    exp_q.delete();
    pos       = 0;
    model_blk = 0;
    bus.dout_ready = 1'b1;
    got_q.delete();
    load_block(rand_blk());
    for (int i = 0; i < 16; i++) send_word($urandom());
    drain();
    checks++; if (bus.blk_count !== 32'd1) begin errors++; $display("FAIL restart_blk got %0d required 1", bus.blk_count); end
  endtask

  task automatic test_reset_mid_block();
    reset_dut();
    load_block(rand_blk());
    for (int i = 0; i < 5; i++) send_word($urandom());
    reset_dut();
    checks++;
    if (bus.ks_req !== 1'b1 || bus.blk_count !== 32'h0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset got req=%b blk=%0d v=%b required req=1 blk=0 v=0",
               bus.ks_req, bus.blk_count, bus.dout_valid);
    end
    load_block(rand_blk());
    for (int i = 0; i < 16; i++) send_word($urandom());
    drain();
  endtask

  task automatic test_round_trip();
    logic [511:0] blk;
    logic [31:0]  pt [16];
    logic [31:0]  ct[$];
    reset_dut();
    blk = rand_blk();
    for (int i = 0; i < 16; i++) pt[i] = $urandom();
    load_block(blk);
    for (int i = 0; i < 16; i++) send_word(pt[i]);
    drain();
    ct = got_q;
    got_q.delete();
    load_block(blk);
    for (int i = 0; i < 16; i++) send_word((i < ct.size()) ? ct[i] : 32'h0);
    drain();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== pt[i]) begin
        errors++;
        $display("FAIL round_trip_w%0d got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 32'hx, pt[i]);
      end
    end
  endtask

  task automatic test_random_traffic();
    reset_dut();
    rand_rdy_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      load_block(rand_blk());
      for (int i = 0; i < 16; i++) begin
        send_word($urandom());
        repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
      end
    end
    rand_rdy_en = 1'b0;
    drain();
    checks++; if (bus.blk_count !== 32'(model_blk)) begin errors++; $display("FAIL random_blk got %0d required %0d", bus.blk_count, model_blk); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_counting_block();
    test_deadbeef();
    test_backpressure();
    test_back_to_back();
    test_restart();
    test_reset_mid_block();
    test_round_trip();
    test_random_traffic();
    repeat (2) @(posedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
